// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the program-counter / instruction-fetch controller.
// Contents: FSM state type, address/instruction widths, default parameter
// values, the HLT opcode seen by the decoder, and the PC adder helper.
package pc_fetch_ctrl_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT      = 16'h0000;
  localparam logic [PC_W-1:0] PC_INC_DEFAULT        = 16'h0002;
  localparam int unsigned     FETCH_TIMEOUT_DEFAULT = 15;

  // Opcode of HLT in bits [15:12]; the decoder uses it to raise halt_detect.
  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DELIVER = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  // Sequential PC step; wraps silently at 2^16.
  function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                             input logic [PC_W-1:0] inc);
    return pc + inc;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of the decode-side, redirect and instruction-memory signals of the
// fetch controller.
//   master : the controller (drives imem request/address and decode outputs)
//   slave  : the environment (decode stage, redirect sources, instruction memory)
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               flush;
  logic [PC_W-1:0]    flush_pc;
  logic               halt_detect;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc_plus2;
  logic               halted;
  logic               fetch_err;

  modport master (
    input  stall, branch_taken, branch_target, flush, flush_pc, halt_detect,
           imem_ack, imem_data,
    output imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus2,
           halted, fetch_err
  );

  modport slave (
    output stall, branch_taken, branch_target, flush, flush_pc, halt_detect,
           imem_ack, imem_data,
    input  imem_req, imem_addr, instr_out, instr_valid, pc_out, pc_plus2,
           halted, fetch_err
  );

endinterface

// File: rtl/pc_fetch_ctrl_pc_next_sel.sv
// Next-PC selector for the fetch controller (purely combinational).
// Ports:
//   i_state          current controller state
//   i_pc/i_pc_plus2  current PC and its sequential successor
//   i_flush, i_flush_pc            external redirect
//   i_stall, i_halt_detect         hold conditions while delivering
//   i_branch_taken, i_branch_target branch redirect
//   o_next_pc        value the PC register loads on the next edge
module pc_fetch_ctrl_pc_next_sel
  import pc_fetch_ctrl_pkg::*;
(
  input  state_t          i_state,
  input  logic [PC_W-1:0] i_pc,
  input  logic [PC_W-1:0] i_pc_plus2,
  input  logic            i_flush,
  input  logic [PC_W-1:0] i_flush_pc,
  input  logic            i_stall,
  input  logic            i_halt_detect,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_branch_target,
  output logic [PC_W-1:0] o_next_pc
);

  // Priority: flush, then stall/halt hold, then branch, then sequential step.
  always_comb begin
    o_next_pc = i_pc;
    case (i_state)
      ST_FETCH: begin
        if (i_flush) begin
          o_next_pc = i_flush_pc;
        end else begin
          o_next_pc = i_pc;
        end
      end
      ST_DELIVER: begin
        if (i_flush) begin
          o_next_pc = i_flush_pc;
        end else if (i_stall || i_halt_detect) begin
          // A halted PC stays on the HLT instruction's address.
          o_next_pc = i_pc;
        end else if (i_branch_taken) begin
          o_next_pc = i_branch_target;
        end else begin
          o_next_pc = i_pc_plus2;
        end
      end
      default: o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active low (0 = reset)
//   bus  pc_fetch_ctrl_if.master: redirect inputs, imem handshake, decode outputs
// Flow: BOOT (one idle cycle) -> FETCH (request until ack) -> DELIVER (present
// instruction, then advance PC) -> FETCH ...; HLT or a fetch timeout end in
// HALTED, which only reset leaves.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC      = RESET_PC_DEFAULT,
  parameter logic [PC_W-1:0] PC_INC        = PC_INC_DEFAULT,
  parameter int unsigned     FETCH_TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  pc_fetch_ctrl_if.master bus
);

  // Error fires on the FETCH_TIMEOUT-th consecutive cycle without ack.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t             r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [7:0]         r_wait;
  logic               r_fetch_err;

  state_t             w_next_state;
  logic [PC_W-1:0]    w_next_pc;
  logic [PC_W-1:0]    w_pc_plus2;
  logic [INSTR_W-1:0] w_next_instr;
  logic [7:0]         w_next_wait;
  logic               w_next_err;

  assign w_pc_plus2 = pc_add(r_pc, PC_INC);

  pc_fetch_ctrl_pc_next_sel u_pc_next_sel (
    .i_state         (r_state),
    .i_pc            (r_pc),
    .i_pc_plus2      (w_pc_plus2),
    .i_flush         (bus.flush),
    .i_flush_pc      (bus.flush_pc),
    .i_stall         (bus.stall),
    .i_halt_detect   (bus.halt_detect),
    .i_branch_taken  (bus.branch_taken),
    .i_branch_target (bus.branch_target),
    .o_next_pc       (w_next_pc)
  );

  // Next-state, instruction capture, wait counter and sticky error decision.
  always_comb begin
    w_next_state = r_state;
    w_next_instr = r_instr;
    w_next_wait  = r_wait;
    w_next_err   = r_fetch_err;
    case (r_state)
      ST_BOOT: begin
        w_next_state = ST_FETCH;
        w_next_wait  = 8'd0;
      end
      ST_FETCH: begin
        if (bus.flush) begin
          // Redirect wins; a coincident ack belongs to the old address.
          w_next_wait = 8'd0;
        end else if (bus.imem_ack) begin
          w_next_instr = bus.imem_data;
          w_next_wait  = 8'd0;
          w_next_state = ST_DELIVER;
        end else if (r_wait == TIMEOUT_LAST) begin
          w_next_err   = 1'b1;
          w_next_wait  = 8'd0;
          w_next_state = ST_HALTED;
        end else begin
          w_next_wait = r_wait + 8'd1;
        end
      end
      ST_DELIVER: begin
        if (bus.flush) begin
          w_next_state = ST_FETCH;
        end else if (bus.stall) begin
          w_next_state = ST_DELIVER;
        end else if (bus.halt_detect) begin
          w_next_state = ST_HALTED;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_BOOT;
    endcase
  end

  // State, PC, instruction, wait counter and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_instr     <= 16'h0000;
      r_wait      <= 8'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_instr     <= w_next_instr;
      r_wait      <= w_next_wait;
      r_fetch_err <= w_next_err;
    end
  end

  assign bus.imem_req    = (r_state == ST_FETCH);
  assign bus.imem_addr   = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = (r_state == ST_DELIVER);
  assign bus.pc_out      = r_pc;
  assign bus.pc_plus2    = w_pc_plus2;
  assign bus.halted      = (r_state == ST_HALTED);
  assign bus.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl #(
    .RESET_PC      (16'h0000),
    .PC_INC        (16'h0002),
    .FETCH_TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "booting", "holding an instruction for decode",
  // "halted", plus pc, latched instruction and consecutive no-ack count.
  bit          m_boot, m_hold, m_halt, m_err;
  int          m_wait, m_pc;
  logic [15:0] m_instr;

  task automatic model_reset();
    m_boot = 1'b1; m_hold = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    m_wait = 0; m_pc = 0; m_instr = 16'h0000;
  endtask

  task automatic model_step();
    if (m_halt) begin
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_hold) begin
      if (bus.flush) begin
        m_pc = int'(bus.flush_pc); m_wait = 0;
      end else if (bus.imem_ack) begin
        m_instr = bus.imem_data; m_wait = 0; m_hold = 1'b1;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait == TIMEOUT) begin m_err = 1'b1; m_halt = 1'b1; end
      end
    end else begin
      if (bus.flush) begin
        m_pc = int'(bus.flush_pc); m_hold = 1'b0;
      end else if (bus.stall) begin
      end else if (bus.halt_detect) begin
        m_hold = 1'b0; m_halt = 1'b1;
      end else if (bus.branch_taken) begin
        m_pc = int'(bus.branch_target); m_hold = 1'b0;
      end else begin
        m_pc = (m_pc + 2) % 65536; m_hold = 1'b0;
      end
    end
  endtask

  function automatic logic [67:0] model_outputs();
    logic [15:0] pc16, pc2;
    pc16 = 16'(m_pc);
    pc2  = 16'((m_pc + 2) % 65536);
    return {(!m_boot && !m_hold && !m_halt), pc16, m_instr, m_hold,
            pc16, pc2, m_halt, m_err};
  endfunction

  function automatic logic [67:0] dut_outputs();
    return {bus.imem_req, bus.imem_addr, bus.instr_out, bus.instr_valid,
            bus.pc_out, bus.pc_plus2, bus.halted, bus.fetch_err};
  endfunction

  function automatic logic [15:0] pat(input int a);
    return 16'(a) ^ 16'hC3A5;
  endfunction

  // One clock: model advances on the same edge as the DUT, return at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    bus.flush = 1'b0; bus.flush_pc = 16'h0000; bus.halt_detect = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #3;
    checks++;
    if (dut_outputs() !== {1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_outputs(),
               {1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    logic [15:0] addrs[$];
    bit          seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.imem_ack = 1'b1;
      bus.imem_data = pat(m_pc);
      checks++;
      if (bus.instr_valid !== ((k >= 2) && (k % 2 == 0))) begin
        errors++;
        $display("FAIL seq_valid k=%0d got=%b exp=%b", k, bus.instr_valid, (k >= 2) && (k % 2 == 0));
      end
      if (bus.imem_req === 1'b1) addrs.push_back(bus.imem_addr);
      if (bus.instr_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1'b1;
        checks++;
        if (bus.pc_out !== 16'h0000 || bus.instr_out !== pat(0)) begin
          errors++;
          $display("FAIL seq_first_valid pc=%h instr=%h exp pc=0000 instr=%h", bus.pc_out, bus.instr_out, pat(0));
        end
      end
      tick();
    end
    bus.imem_ack = 1'b0;
    checks++;
    if (addrs.size() != 3 || addrs[0] !== 16'h0000 || addrs[1] !== 16'h0002 || addrs[2] !== 16'h0004) begin
      errors++;
      $display("FAIL seq_addrs got n=%0d %p exp 0000,0002,0004", addrs.size(), addrs);
    end
  endtask

  task automatic test_branch();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.pc_out !== 16'h0004) begin
      errors++;
      $display("FAIL branch_pre valid=%b pc=%h exp valid=1 pc=0004", bus.instr_valid, bus.pc_out);
    end
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0100;
    tick();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100 || bus.pc_plus2 !== 16'h0102) begin
      errors++;
      $display("FAIL branch_redirect req=%b addr=%h pc2=%h exp 1/0100/0102", bus.imem_req, bus.imem_addr, bus.pc_plus2);
    end
    bus.imem_ack = 1'b1; bus.imem_data = pat(16'h0100);
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0300;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.instr_out, bus.pc_out, bus.instr_valid} !== {pat(16'h0100), 16'h0100, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold k=%0d instr=%h pc=%h valid=%b exp %h/0100/1", k, bus.instr_out, bus.pc_out, bus.instr_valid, pat(16'h0100));
      end
    end
    bus.stall = 1'b0;
    tick();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.imem_addr !== 16'h0300 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL stall_release addr=%h valid=%b req=%b exp 0300/0/1", bus.imem_addr, bus.instr_valid, bus.imem_req);
    end
  endtask

  task automatic test_flush_ack();
    bus.flush = 1'b1; bus.flush_pc = 16'h0010;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.imem_addr !== 16'h0010 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup addr=%h req=%b exp 0010/1", bus.imem_addr, bus.imem_req);
    end
    bus.flush = 1'b1; bus.flush_pc = 16'h0200; bus.imem_ack = 1'b1; bus.imem_data = 16'hABCD;
    tick();
    bus.flush = 1'b0; bus.imem_ack = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 16'h0200 || bus.instr_out === 16'hABCD) begin
      errors++;
      $display("FAIL flush_ack valid=%b addr=%h instr=%h exp 0/0200/not ABCD", bus.instr_valid, bus.imem_addr, bus.instr_out);
    end
    bus.imem_ack = 1'b1; bus.imem_data = pat(16'h0200);
    tick();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== pat(16'h0200)) begin
      errors++;
      $display("FAIL flush_refetch valid=%b instr=%h exp 1/%h", bus.instr_valid, bus.instr_out, pat(16'h0200));
    end
  endtask

  task automatic test_wrap_halt();
    bus.flush = 1'b1; bus.flush_pc = 16'hFFFE;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.imem_addr !== 16'hFFFE || bus.pc_plus2 !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_plus2 addr=%h pc2=%h exp FFFE/0000", bus.imem_addr, bus.pc_plus2);
    end
    bus.imem_ack = 1'b1; bus.imem_data = pat(16'hFFFE);
    tick();
    bus.imem_ack = 1'b0;
    tick();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr req=%b addr=%h exp 1/0000", bus.imem_req, bus.imem_addr);
    end
    bus.imem_ack = 1'b1; bus.imem_data = 16'hF000;
    tick();
    bus.imem_ack = 1'b0;
    bus.halt_detect = 1'b1;
    tick();
    bus.halt_detect = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL halt_frozen k=%0d halted=%b req=%b valid=%b pc=%h exp 1/0/0/0000", k, bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out);
      end
      bus.flush = 1'($urandom_range(0, 1)); bus.flush_pc = 16'h0400; bus.imem_ack = 1'b1;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_timeout_reset();
    int n = 0;
    do_reset();
    tick();
    bus.flush = 1'b1; bus.flush_pc = 16'h1234;
    tick();
    bus.flush = 1'b0;
    while (bus.fetch_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != TIMEOUT || bus.halted !== 1'b1 || bus.pc_out !== 16'h1234) begin
      errors++;
      $display("FAIL timeout wait_cycles=%0d halted=%b pc=%h exp %0d/1/1234", n, bus.halted, bus.pc_out, TIMEOUT);
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.fetch_err, bus.halted, bus.pc_out} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset err=%b halted=%b pc=%h exp 0/0/0000", bus.fetch_err, bus.halted, bus.pc_out);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      checks++;
      if (dut_outputs() !== model_outputs()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, dut_outputs(), model_outputs());
      end
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        bus.imem_ack      = ($urandom_range(0, 9) < 6);
        bus.imem_data     = 16'($urandom);
        bus.stall         = ($urandom_range(0, 9) < 3);
        bus.branch_taken  = ($urandom_range(0, 9) < 3);
        bus.branch_target = 16'($urandom);
        bus.flush         = ($urandom_range(0, 24) == 0);
        bus.flush_pc      = 16'($urandom);
        bus.halt_detect   = ($urandom_range(0, 39) == 0);
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_flush_ack();
    test_wrap_halt();
    test_timeout_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the 16-bit program counter and the instruction-fetch handshake with instruction memory.
- Decides when the PC register is written (increment, branch redirect, flush redirect) and when it holds (stall, halt).
- Delivers each fetched instruction to decode with a valid flag.
- Sits between the PC storage / instruction memory and the decode stage.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 2, byte increment per sequential instruction
FETCH_TIMEOUT, 15, max cycles waiting for imem_ack before fetch error (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
stall  input  1  decode cannot accept; hold current instruction and PC
branch_taken  input  1  current delivered instruction redirects PC
branch_target  input  16  redirect address, used with branch_taken
flush  input  1  external redirect (exception or replay) with flush_pc
flush_pc  input  16  redirect address for flush
halt_detect  input  1  current delivered instruction is HLT
imem_req  output  1  fetch request
imem_addr  output  16  fetch address (= pc_out)
imem_ack  input  1  imem_data valid for imem_addr this cycle
imem_data  input  16  instruction word
instr_out  output  16  registered instruction to decode
instr_valid  output  1  instr_out valid
pc_out  output  16  current PC
pc_plus2  output  16  pc_out + PC_INC (mod 2^16), combinational
halted  output  1  processor halted (sticky until reset)
fetch_err  output  1  fetch timed out (sticky until reset)

Behaviour:
- Reset (rst = 0, any time, asynchronous):
  - State goes to BOOT; pc = RESET_PC; instr_out = 0.
  - instr_valid, imem_req, halted and fetch_err are 0; the wait counter is 0.
  - Any in-flight fetch is abandoned.
- BOOT: one cycle with all outputs idle, then FETCH.
- FETCH:
  - imem_req = 1 and imem_addr = pc. The wait counter increments each cycle without imem_ack.
  - flush = 1 takes priority over everything: pc <= flush_pc, counter <= 0, stay in FETCH. A coincident imem_ack is discarded.
  - Otherwise, on imem_ack: instr_out <= imem_data, counter <= 0, go to DELIVER. The instruction is visible the next cycle, so fetch latency is ack + 1 cycle.
  - If the counter reaches FETCH_TIMEOUT with no ack: fetch_err <= 1, go to HALTED.
- DELIVER (instr_valid = 1, imem_req = 0), evaluated in this priority order:
  1. flush: pc <= flush_pc, go to FETCH, no halt.
  2. stall: hold pc, instr_out and state. branch_taken and halt_detect are ignored while stalled.
  3. halt_detect: go to HALTED; pc holds at the HLT address.
  4. branch_taken: pc <= branch_target, go to FETCH.
  5. Otherwise: pc <= pc + PC_INC, go to FETCH.
- HALTED:
  - halted = 1, instr_valid = 0, imem_req = 0, pc frozen.
  - flush is ignored. Exit only via reset.
- PC write rules:
  - pc is written only on the transitions listed above; all other cycles hold it.
  - Arithmetic is 16-bit unsigned: 16'hFFFE + 2 wraps to 16'h0000 with no flag.
  - Odd branch_target and flush_pc values are loaded unmodified.
- instr_valid is exactly (state == DELIVER). It never asserts in the cycle an ack is accepted.
- Releasing reset mid-fetch always restarts with BOOT, then a fetch of RESET_PC.

Decomposition:
- Shared package:
  - state enum {BOOT, FETCH, DELIVER, HALTED}, 2-bit encoding.
  - Constants: RESET_PC default, PC_INC default, instruction width 16, HLT opcode 4'hF used by the decoder driving halt_detect.
- One combinational sub-module, pc_next_sel: selects among flush_pc / branch_target / pc+PC_INC / pc according to the priority above.
- The FSM, wait counter and PC/instruction registers stay in pc_fetch_ctrl.

Test Plan:
- Reset and sequential fetch: rst low then high, imem_ack=1 every FETCH cycle.
  - imem_addr sequence is 0x0000, 0x0002, 0x0004.
  - instr_valid pulses every 2nd cycle after BOOT.
  - pc_out is 0x0000 at first valid.
- Branch: at DELIVER with pc=0x0004, branch_taken=1, branch_target=0x0100.
  - Next imem_addr = 0x0100 and pc_plus2 = 0x0102.
  - 0x0006 is never requested.
- Stall: hold stall=1 for 3 DELIVER cycles with branch_taken=1.
  - instr_out, pc_out and instr_valid are stable for 3 cycles.
  - The branch takes effect only on the first unstalled cycle.
- Flush with coincident ack: in FETCH at pc=0x0010, flush=1, flush_pc=0x0200, imem_ack=1, imem_data=0xABCD.
  - instr_valid stays 0 and 0xABCD is never delivered.
  - Next imem_addr = 0x0200.
- Halt and wrap:
  - pc=0xFFFE with a normal instruction: next imem_addr = 0x0000.
  - Next delivered instruction with halt_detect=1: halted=1, pc_out frozen at 0x0000, imem_req stays 0 for 20 cycles, flush ignored.
- Timeout and async reset: FETCH_TIMEOUT=15, imem_ack held 0.
  - fetch_err=1 and halted=1 after 15 wait cycles.
  - Asserting rst mid-cycle clears both immediately, without waiting for a clock edge, and pc_out = RESET_PC.
